// File: rtl/strait_bist_pkg.sv
// Shared types and helpers for the STRAIT array BIST sequencer.
// Latency: n/a (types, constants and pure combinational functions).
// Backpressure: n/a.
// Contents: FSM state encoding, default LFSR polynomial/seed, word rotate, Galois LFSR step.
package strait_bist_pkg;

   // Word width the helper functions operate on; the sequencer's DATA_WIDTH must match it.
   localparam int unsigned DW = 32;

   localparam logic [DW-1:0] POLY_DEF = 32'h8020_0003;  // x^32+x^22+x^2+x+1, right-shift Galois
   localparam logic [DW-1:0] SEED_DEF = 32'hACE1_2024;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_CMP     = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   // Rotate left by (amt mod DW). Called with constant amounts only, so it reduces to wiring.
   function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input int unsigned amt);
      int unsigned a;
      a = amt % DW;
      return (a == 0) ? v : ((v << a) | (v >> (DW - a)));
   endfunction

   // One Galois right-shift step: bit 0 shifted out folds the polynomial back in.
   function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s, input logic [DW-1:0] poly);
      return (s >> 1) ^ (s[0] ? poly : '0);
   endfunction

endpackage

// File: rtl/strait_bist_ctrl_if.sv
// Bundle of host-control and array-facing signals of the BIST sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the array is a fixed-rate scan target.
// master = sequencer side (drives scan_en/in_A/in_W/scan_in_p/status), slave = host + array side.
interface strait_bist_ctrl_if #(
   parameter int N          = 16,
   parameter int DATA_WIDTH = 32
);
   logic                      start;
   logic [DATA_WIDTH-1:0]     golden_sig;
   logic                      scan_en;
   logic [N*DATA_WIDTH-1:0]   in_A;
   logic [N*DATA_WIDTH-1:0]   in_W;
   logic [N*DATA_WIDTH-1:0]   scan_in_p;
   logic [N*DATA_WIDTH-1:0]   scan_out_p;
   logic                      busy;
   logic                      done;
   logic                      pass;
   logic [DATA_WIDTH-1:0]     signature;

   modport master (
      input  start, golden_sig, scan_out_p,
      output scan_en, in_A, in_W, scan_in_p, busy, done, pass, signature
   );

   modport slave (
      output start, golden_sig, scan_out_p,
      input  scan_en, in_A, in_W, scan_in_p, busy, done, pass, signature
   );
endinterface

// File: rtl/strait_lfsr_misr.sv
// Galois shift register with synchronous load and XOR data input; serves as LFSR (data=0) or MISR.
// Latency: q reflects load/step one cycle after the enabling edge.
// Backpressure: none; load has priority over en, otherwise holds.
// Ports: clk, rst (async high), en, load, load_val, data, q.
module strait_lfsr_misr
   import strait_bist_pkg::*;
#(
   parameter logic [DW-1:0] POLY    = POLY_DEF,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] q
);

   logic [DW-1:0] reg_q;
   logic [DW-1:0] reg_d;

   always_comb begin
      reg_d = reg_q;
      if (load) begin
         reg_d = load_val;
      end else if (en) begin
         reg_d = lfsr_step(reg_q, POLY) ^ data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_q <= RST_VAL;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign q = reg_q;

endmodule

// File: rtl/strait_bist_ctrl.sv
// BIST sequencer for the N x N STRAIT array: LFSR patterns in, MISR-compacted scan stream out.
// Latency: start-to-DONE = NUM_PATTERNS*(N+1) + N + 1 cycles; all outputs registered-state decode.
// Backpressure: none; start is ignored while busy, a start in DONE restarts the run.
// Ports: clk, rst (async high), bus (master: start/golden_sig/scan_out_p in; scan_en/in_A/in_W/
//        scan_in_p/busy/done/pass/signature out).
module strait_bist_ctrl
   import strait_bist_pkg::*;
#(
   parameter int              N            = 16,
   parameter int              DATA_WIDTH   = DW,
   parameter int              NUM_PATTERNS = 64,
   parameter logic [DW-1:0]   POLY         = POLY_DEF,
   parameter logic [DW-1:0]   SEED         = SEED_DEF
) (
   input logic                 clk,
   input logic                 rst,
   strait_bist_ctrl_if.master  bus
);

   localparam int SHW = (N > 1) ? $clog2(N) : 1;
   localparam int PCW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
   localparam logic [SHW-1:0] SH_LAST  = SHW'(N - 1);
   localparam logic [PCW-1:0] PAT_LAST = PCW'(NUM_PATTERNS - 1);

   state_e                  state_q, state_d;
   logic [SHW-1:0]          sh_cnt_q, sh_cnt_d;
   logic [PCW-1:0]          pat_cnt_q, pat_cnt_d;
   logic                    pass_q, pass_d;
   logic                    run_load;
   logic                    lfsr_en;
   logic                    misr_en;
   logic [DATA_WIDTH-1:0]   lfsr_q;
   logic [DATA_WIDTH-1:0]   misr_q;
   logic [DATA_WIDTH-1:0]   fold;

   always_comb begin
      state_d   = state_q;
      sh_cnt_d  = sh_cnt_q;
      pat_cnt_d = pat_cnt_q;
      pass_d    = pass_q;
      run_load  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d   = ST_SHIFT;
               sh_cnt_d  = '0;
               pat_cnt_d = '0;
               pass_d    = 1'b0;
               run_load  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (sh_cnt_q == SH_LAST) begin
               sh_cnt_d = '0;
               state_d  = ST_CAPTURE;
            end else begin
               sh_cnt_d = sh_cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (pat_cnt_q == PAT_LAST) begin
               state_d = ST_UNLOAD;
            end else begin
               pat_cnt_d = pat_cnt_q + 1'b1;
               state_d   = ST_SHIFT;
            end
         end
         ST_UNLOAD: begin
            if (sh_cnt_q == SH_LAST) begin
               sh_cnt_d = '0;
               state_d  = ST_CMP;
            end else begin
               sh_cnt_d = sh_cnt_q + 1'b1;
            end
         end
         ST_CMP: begin
            pass_d  = (misr_q == bus.golden_sig);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sh_cnt_q  <= '0;
         pat_cnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_cnt_q  <= sh_cnt_d;
         pat_cnt_q <= pat_cnt_d;
         pass_q    <= pass_d;
      end
   end

   assign lfsr_en = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE);
   // The first pattern's shift pushes out post-reset chain contents, which are not deterministic.
   assign misr_en = ((state_q == ST_SHIFT) && (pat_cnt_q != '0)) || (state_q == ST_UNLOAD);

   always_comb begin
      fold = '0;
      for (int m = 0; m < N; m++) begin
         fold ^= bus.scan_out_p[m*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   strait_lfsr_misr #(.POLY(POLY), .RST_VAL(SEED)) u_lfsr (
      .clk(clk), .rst(rst), .en(lfsr_en), .load(run_load),
      .load_val(SEED), .data('0), .q(lfsr_q)
   );

   strait_lfsr_misr #(.POLY(POLY), .RST_VAL('0)) u_misr (
      .clk(clk), .rst(rst), .en(misr_en), .load(run_load),
      .load_val('0), .data(fold), .q(misr_q)
   );

   for (genvar m = 0; m < N; m++) begin : g_lane
      assign bus.scan_in_p[m*DATA_WIDTH +: DATA_WIDTH] = (state_q == ST_SHIFT)   ? rotl(lfsr_q, m)  : '0;
      assign bus.in_A[m*DATA_WIDTH +: DATA_WIDTH]      = (state_q == ST_CAPTURE) ? rotl(lfsr_q, m)  : '0;
      assign bus.in_W[m*DATA_WIDTH +: DATA_WIDTH]      = (state_q == ST_CAPTURE) ? rotl(~lfsr_q, m) : '0;
   end

   assign bus.scan_en   = (state_q != ST_CAPTURE);
   assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE) ||
                          (state_q == ST_UNLOAD) || (state_q == ST_CMP);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.pass      = pass_q;
   assign bus.signature = misr_q;

endmodule

// File: tb/tb_strait_bist_ctrl.sv
// Bench for strait_bist_ctrl (N=4, 32-bit, 2 patterns) with an attached array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_strait_bist_ctrl;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int NP = 2;
   localparam logic [31:0] POLY = 32'h8020_0003;
   localparam logic [31:0] SEED = 32'hACE1_2024;
   localparam int T  = NP*(N+1) + N + 1;   // first DONE cycle
   localparam int NC = T + 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   strait_bist_ctrl_if #(.N(N), .DATA_WIDTH(DW)) bus ();

   strait_bist_ctrl #(.N(N), .DATA_WIDTH(DW), .NUM_PATTERNS(NP), .POLY(POLY), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int vectors = 0;
   int errors  = 0;

   logic [31:0] arr [N][N];   // attached array: P-chains, row m position n
   logic        rec_en [NC];
   logic        rec_busy [NC];
   logic        rec_done [NC];
   logic [31:0] rec_sip0 [NC];
   logic [31:0] rec_sip1 [NC];
   logic [31:0] rec_a0 [NC];
   logic [31:0] rec_w1 [NC];
   logic [31:0] rec_sig [NC];
   int          done_cyc;
   logic [31:0] sched_misr;

   function automatic logic [31:0] m_step(input logic [31:0] s);
      if (s[0]) return (s >> 1) ^ POLY;
      return s >> 1;
   endfunction

   function automatic logic [31:0] m_rotl(input logic [31:0] v, input int k);
      logic [63:0] d;
      d = {v, v};
      return d[63-(k%32) -: 32];
   endfunction

   // Whether run cycle c (0 = first SHIFT cycle) folds scan_out_p into the signature.
   function automatic bit compacts(input int c);
      int p, k;
      p = c / (N+1);
      k = c % (N+1);
      if (p < NP) return (k < N) && (p != 0);
      return (c - NP*(N+1)) < N;
   endfunction

   // Full run of LFSR -> array -> MISR from the rules, optional single-bit fold corruption.
   function automatic logic [31:0] ref_array_sig(input int flip_cyc, input int flip_bit);
      logic [31:0] ch [N][N];
      logic [31:0] l, misr, f;
      int c;
      l = SEED; misr = '0; c = 0;
      foreach (ch[i, j]) ch[i][j] = '0;
      for (int p = 0; p < NP; p++) begin
         for (int k = 0; k < N; k++) begin
            f = '0;
            for (int m = 0; m < N; m++) f ^= ch[m][N-1];
            if (c == flip_cyc) f ^= (32'd1 << flip_bit);
            if (p != 0) misr = m_step(misr) ^ f;
            for (int m = 0; m < N; m++) begin
               for (int j = N-1; j > 0; j--) ch[m][j] = ch[m][j-1];
               ch[m][0] = m_rotl(l, m);
            end
            l = m_step(l); c++;
         end
         for (int m = 0; m < N; m++)
            for (int n = 0; n < N; n++)
               ch[m][n] = ch[m][n] + m_rotl(l, m) * m_rotl(~l, n);
         l = m_step(l); c++;
      end
      for (int k = 0; k < N; k++) begin
         f = '0;
         for (int m = 0; m < N; m++) f ^= ch[m][N-1];
         if (c == flip_cyc) f ^= (32'd1 << flip_bit);
         misr = m_step(misr) ^ f;
         for (int m = 0; m < N; m++) begin
            for (int j = N-1; j > 0; j--) ch[m][j] = ch[m][j-1];
            ch[m][0] = '0;
         end
         c++;
      end
      return misr;
   endfunction

   // Drives one run starting at a negedge. src: 0 zeros, 1 array model, 2 random words.
   // gold_mode: 0 fixed gold_val, 1 running reference, 2 running reference ^ gold_val.
   task automatic run(input int src, input int flip_cyc, input int rst_cyc, input int gold_mode,
                      input logic [31:0] gold_val, input int stray);
      logic [31:0] v, f, rm;
      done_cyc = -1;
      rm = '0;
      if (gold_mode == 0) bus.golden_sig = gold_val;
      bus.start = 1'b1;
      @(posedge clk);
      for (int c = 0; c < NC; c++) begin
         @(negedge clk);
         bus.start = (stray != 0 && c < T) ? 1'($urandom_range(0, 1)) : 1'b0;
         rec_en[c]   = bus.scan_en;
         rec_busy[c] = bus.busy;
         rec_done[c] = bus.done;
         rec_sip0[c] = bus.scan_in_p[31:0];
         rec_sip1[c] = bus.scan_in_p[63:32];
         rec_a0[c]   = bus.in_A[31:0];
         rec_w1[c]   = bus.in_W[63:32];
         rec_sig[c]  = bus.signature;
         if (done_cyc < 0 && bus.done === 1'b1) done_cyc = c;
         if (c == rst_cyc) begin
            rst = 1'b1;
            bus.start = 1'b0;
            return;
         end
         f = '0;
         for (int m = 0; m < N; m++) begin
            if (src == 0)      v = '0;
            else if (src == 1) v = arr[m][N-1];
            else               v = $urandom;
            if (c == flip_cyc && m == 2) v ^= 32'h0000_0100;
            bus.scan_out_p[m*DW +: DW] = v;
            f ^= v;
         end
         if (compacts(c)) rm = m_step(rm) ^ f;
         if (c == T-1 && gold_mode == 1) bus.golden_sig = rm;
         if (c == T-1 && gold_mode == 2) bus.golden_sig = rm ^ gold_val;
         if (src == 1) begin
            for (int m = 0; m < N; m++) begin
               if (bus.scan_en) begin
                  for (int j = N-1; j > 0; j--) arr[m][j] = arr[m][j-1];
                  arr[m][0] = bus.scan_in_p[m*DW +: DW];
               end else begin
                  for (int n = 0; n < N; n++)
                     arr[m][n] = arr[m][n] + bus.in_A[m*DW +: DW] * bus.in_W[n*DW +: DW];
               end
            end
         end
      end
      bus.scan_out_p = '0;
      sched_misr = rm;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.golden_sig = '0;
      bus.scan_out_p = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      vectors += 8;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", bus.pass); end
      if (bus.scan_en !== 1'b1) begin errors++; $display("FAIL reset_scan_en got %b want 1", bus.scan_en); end
      if (bus.signature !== 32'd0) begin errors++; $display("FAIL reset_sig got %h want 0", bus.signature); end
      if (bus.in_A !== '0) begin errors++; $display("FAIL reset_in_A got %h want 0", bus.in_A); end
      if (bus.in_W !== '0) begin errors++; $display("FAIL reset_in_W got %h want 0", bus.in_W); end
      if (bus.scan_in_p !== '0) begin errors++; $display("FAIL reset_scan_in got %h want 0", bus.scan_in_p); end
   endtask

   task automatic test_timeline();
      logic e_en, e_busy, e_done;
      logic [31:0] l4;
      run(0, -1, -1, 0, 32'd0, 0);
      for (int c = 0; c <= T; c++) begin
         e_en   = !((c < NP*(N+1)) && (c % (N+1) == N));
         e_busy = (c < T);
         e_done = (c == T);
         vectors += 4;
         if (rec_en[c] !== e_en) begin errors++; $display("FAIL scan_en cyc %0d got %b want %b", c, rec_en[c], e_en); end
         if (rec_busy[c] !== e_busy) begin errors++; $display("FAIL busy cyc %0d got %b want %b", c, rec_busy[c], e_busy); end
         if (rec_done[c] !== e_done) begin errors++; $display("FAIL done cyc %0d got %b want %b", c, rec_done[c], e_done); end
         if (rec_sig[c] !== 32'd0) begin errors++; $display("FAIL zero_sig cyc %0d got %h want 0", c, rec_sig[c]); end
      end
      l4 = SEED;
      for (int i = 0; i < N; i++) l4 = m_step(l4);
      vectors += 8;
      if (done_cyc !== T) begin errors++; $display("FAIL done_latency got %0d want %0d", done_cyc, T); end
      if (bus.pass !== 1'b1) begin errors++; $display("FAIL zero_pass got %b want 1", bus.pass); end
      if (rec_sip0[0] !== SEED) begin errors++; $display("FAIL sip_row0_c0 got %h want %h", rec_sip0[0], SEED); end
      if (rec_sip1[0] !== m_rotl(SEED, 1)) begin errors++; $display("FAIL sip_row1_c0 got %h want %h", rec_sip1[0], m_rotl(SEED, 1)); end
      if (rec_sip0[1] !== m_step(SEED)) begin errors++; $display("FAIL sip_row0_c1 got %h want %h", rec_sip0[1], m_step(SEED)); end
      if (rec_a0[N] !== l4) begin errors++; $display("FAIL cap_in_A got %h want %h", rec_a0[N], l4); end
      if (rec_w1[N] !== m_rotl(~l4, 1)) begin errors++; $display("FAIL cap_in_W got %h want %h", rec_w1[N], m_rotl(~l4, 1)); end
      if (rec_sip0[N] !== 32'd0) begin errors++; $display("FAIL cap_scan_in got %h want 0", rec_sip0[N]); end
   endtask

   task automatic test_golden_mismatch();
      run(0, -1, -1, 0, 32'd1, 0);
      vectors += 2;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL gold1_done got %b want 1", bus.done); end
      if (bus.pass !== 1'b0) begin errors++; $display("FAIL gold1_pass got %b want 0", bus.pass); end
   endtask

   task automatic test_array();
      logic [31:0] r;
      r = ref_array_sig(-1, 0);
      foreach (arr[i, j]) arr[i][j] = $urandom;
      run(1, -1, -1, 0, r, 0);
      vectors += 3;
      if (bus.signature !== r) begin errors++; $display("FAIL array_sig got %h want %h", bus.signature, r); end
      if (bus.pass !== 1'b1) begin errors++; $display("FAIL array_pass got %b want 1", bus.pass); end
      if (done_cyc !== T) begin errors++; $display("FAIL array_latency got %0d want %0d", done_cyc, T); end
   endtask

   task automatic test_flip();
      logic [31:0] r, rf;
      r  = ref_array_sig(-1, 0);
      rf = ref_array_sig(6, 8);
      run(1, 6, -1, 0, r, 0);
      vectors += 2;
      if (bus.signature !== rf) begin errors++; $display("FAIL flip_sig got %h want %h", bus.signature, rf); end
      if (bus.pass !== 1'b0) begin errors++; $display("FAIL flip_pass got %b want 0", bus.pass); end
   endtask

   task automatic test_rst_mid();
      logic [31:0] r;
      r = ref_array_sig(-1, 0);
      run(1, -1, 7, 0, r, 0);
      @(posedge clk);
      #1;
      vectors += 4;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
      if (bus.signature !== 32'd0) begin errors++; $display("FAIL midrst_sig got %h want 0", bus.signature); end
      if (bus.scan_en !== 1'b1) begin errors++; $display("FAIL midrst_scan_en got %b want 1", bus.scan_en); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run(1, -1, -1, 0, r, 0);
      vectors += 2;
      if (bus.signature !== r) begin errors++; $display("FAIL rerun_sig got %h want %h", bus.signature, r); end
      if (bus.pass !== 1'b1) begin errors++; $display("FAIL rerun_pass got %b want 1", bus.pass); end
   endtask

   task automatic test_stray_starts();
      logic [31:0] r;
      r = ref_array_sig(-1, 0);
      run(1, -1, -1, 0, r, 1);
      vectors += 3;
      if (done_cyc !== T) begin errors++; $display("FAIL stray_latency got %0d want %0d", done_cyc, T); end
      if (bus.signature !== r) begin errors++; $display("FAIL stray_sig got %h want %h", bus.signature, r); end
      if (bus.pass !== 1'b1) begin errors++; $display("FAIL stray_pass got %b want 1", bus.pass); end
   endtask

   task automatic test_start_in_done();
      run(0, -1, -1, 0, 32'd0, 0);
      vectors += 4;
      if (rec_done[0] !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", rec_done[0]); end
      if (rec_busy[0] !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", rec_busy[0]); end
      if (done_cyc !== T) begin errors++; $display("FAIL restart_latency got %0d want %0d", done_cyc, T); end
      if (bus.pass !== 1'b1) begin errors++; $display("FAIL restart_pass got %b want 1", bus.pass); end
   endtask

   task automatic test_random();
      int mode;
      logic exp_pass;
      for (int it = 0; it < 6; it++) begin
         mode = $urandom_range(1, 2);
         exp_pass = (mode == 1);
         run(2, -1, -1, mode, $urandom | 32'd1, 0);
         vectors += 3;
         if (bus.signature !== sched_misr) begin errors++; $display("FAIL rand_sig it %0d got %h want %h", it, bus.signature, sched_misr); end
         if (bus.pass !== exp_pass) begin errors++; $display("FAIL rand_pass it %0d got %b want %b", it, bus.pass, exp_pass); end
         if (done_cyc !== T) begin errors++; $display("FAIL rand_latency it %0d got %0d want %0d", it, done_cyc, T); end
      end
   endtask

   initial begin
      test_reset();
      test_timeline();
      test_golden_mismatch();
      test_array();
      test_flip();
      test_rst_mid();
      test_stray_starts();
      test_start_in_done();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
